pwm_dac: RTL and testbench

Converts the 8-bit unsigned sample stream from the sine generator into a single-bit PWM waveform for an RC-filtered output pin. The block fetches one sample per PWM period through a request/valid handshake. It optionally attenuates the sample about mid-scale and latches it as the duty cycle at the period boundary, so the duty never changes mid-period. It sits directly downstream of the waveform generators in the function-generator datapath and drives the board pin.

---
 rtl/fgen_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_dac.sv | 87 ++++++++
 tb/tb_pwm_dac.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fgen_pkg.sv
// Shared constants for the function-generator datapath: sample width,
// mid-scale code and the attenuation shift encodings.
package fgen_pkg;

  localparam int SAMPLE_W = 8;
  localparam int MID      = 1 << (SAMPLE_W - 1);

  localparam logic [1:0] ATT_1 = 2'd0;
  localparam logic [1:0] ATT_2 = 2'd1;
  localparam logic [1:0] ATT_4 = 2'd2;
  localparam logic [1:0] ATT_8 = 2'd3;

endpackage

// File: rtl/pwm_prescaler.sv
// Slot-rate prescaler: emits one tick every PRESCALE enabled clocks.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (tick)    pcnt_d = '0;
    else if (en) pcnt_d = pcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: fetches one sample per period, attenuates it about mid-scale and
// latches it as the duty at the period boundary.
module pwm_dac
  import fgen_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [1:0]       atten,
  output logic             sample_req,
  output logic             underrun,
  output logic             pwm_out
);

  localparam logic signed [WIDTH:0]   HALF_S = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic        [WIDTH-1:0] HALF_U = {1'b1, {(WIDTH-1){1'b0}}};

  // The true result always lies in 0..2^WIDTH-1, so modulo-2^WIDTH addition
  // of the truncated shifted offset is exact.
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] s,
                                             input logic [1:0]       a);
    logic signed [WIDTH:0] d;
    d = $signed({1'b0, s}) - HALF_S;
    return HALF_U + WIDTH'(d >>> a);
  endfunction

  logic             tick, wrap;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] staged_q, staged_d;
  logic             staged_full_q, staged_full_d;
  logic             req_q, req_d;
  logic             und_q, und_d;
  logic             pwm_q, pwm_d;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    wrap          = tick && (cnt_q == '1);
    cnt_d         = tick ? cnt_q + 1'b1 : cnt_q;
    staged_d      = sample_valid ? sample_in : staged_q;
    staged_full_d = wrap ? 1'b0 : (sample_valid ? 1'b1 : staged_full_q);
    duty_d        = duty_q;
    if (wrap) begin
      if (staged_full_q)     duty_d = scale(staged_q, atten);
      else if (sample_valid) duty_d = scale(sample_in, atten);
    end
    req_d = wrap;
    und_d = wrap && !staged_full_q && !sample_valid;
    pwm_d = en && (cnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      duty_q        <= '0;
      staged_q      <= '0;
      staged_full_q <= 1'b0;
      req_q         <= 1'b0;
      und_q         <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      staged_q      <= staged_d;
      staged_full_q <= staged_full_d;
      req_q         <= req_d;
      und_q         <= und_d;
      pwm_q         <= pwm_d;
    end
  end

  assign sample_req = req_q;
  assign underrun   = und_q;
  assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: two instances (PRESCALE 1 and 4) on shared stimulus,
// each compared every clock against a period-arithmetic reference model.
module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       rst, en, sv;
  logic [7:0] sin;
  logic [1:0] att;
  logic       req1, und1, pwm1, req4, und4, pwm4;

  int checks = 0;
  int errors = 0;

  int m_ec[2], m_duty[2], m_stg[2], m_sf[2], m_req[2], m_und[2], m_pwm[2];

  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sin), .sample_valid(sv),
    .atten(att), .sample_req(req1), .underrun(und1), .pwm_out(pwm1)
  );

  pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sin), .sample_valid(sv),
    .atten(att), .sample_req(req4), .underrun(und4), .pwm_out(pwm4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Attenuation about mid-scale with floor division (arithmetic shift).
  function automatic int mscale(input int s, input int a);
    int d, q;
    d = s - 128;
    if (d >= 0) q = d / (1 << a);
    else        q = -((-d + (1 << a) - 1) / (1 << a));
    return 128 + q;
  endfunction

  // The model tracks enabled clocks within the period (0..256*P-1) directly.
  task automatic mstep(input int k);
    int p, slot, tk, wr;
    p = (k == 0) ? 1 : 4;
    if (rst) begin
      m_ec[k] = 0; m_duty[k] = 0; m_stg[k] = 0; m_sf[k] = 0;
      m_req[k] = 0; m_und[k] = 0; m_pwm[k] = 0;
    end else begin
      slot     = m_ec[k] / p;
      tk       = (en && (m_ec[k] % p == p - 1)) ? 1 : 0;
      wr       = (tk == 1 && slot == 255) ? 1 : 0;
      m_pwm[k] = (en && slot < m_duty[k]) ? 1 : 0;
      m_req[k] = wr;
      m_und[k] = (wr == 1 && m_sf[k] == 0 && !sv) ? 1 : 0;
      if (wr == 1) begin
        if (m_sf[k] == 1) m_duty[k] = mscale(m_stg[k], int'(att));
        else if (sv)      m_duty[k] = mscale(int'(sin), int'(att));
      end
      if (sv) m_stg[k] = int'(sin);
      m_sf[k] = (wr == 1) ? 0 : (sv ? 1 : m_sf[k]);
      if (en) m_ec[k] = (m_ec[k] + 1) % (256 * p);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk("pwm_p1", int'(pwm1), m_pwm[0]);
    chk("req_p1", int'(req1), m_req[0]);
    chk("und_p1", int'(und1), m_und[0]);
    chk("pwm_p4", int'(pwm4), m_pwm[1]);
    chk("req_p4", int'(req4), m_req[1]);
    chk("und_p4", int'(und4), m_und[1]);
  endtask

  task automatic wait_req(input int k, input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (((k == 0) ? req1 : req4) == 1'b0 && n < bound);
    chk("req_seen", int'((k == 0) ? req1 : req4), 1);
  endtask

  // One full PRESCALE=1 period starting at a request cycle; optional staging
  // at offsets i1/i2 (offset 256 is the wrap cycle itself).
  task automatic rp(input int s1, input int i1, input int s2, input int i2,
                    input int a, output int highs, output int und_end);
    att   = 2'(a);
    highs = 0;
    for (int i = 1; i <= 256; i++) begin
      sv  = (i == i1) || (i == i2);
      sin = (i == i2) ? 8'(s2) : 8'(s1);
      cycle();
      highs += int'(pwm1);
      if (i == 1) chk("req_pulse_len", int'(req1), 0);
    end
    sv      = 1'b0;
    und_end = int'(und1);
    chk("req_at_wrap", int'(req1), 1);
  endtask

  initial begin
    int n, h, u;
    rst = 1'b1; en = 1'b1; sv = 1'b0; sin = 8'd0; att = 2'd0;
    cycle();
    cycle();
    chk("rst_pwm", int'(pwm1), 0);
    chk("rst_req", int'(req1), 0);
    chk("rst_und", int'(und1), 0);
    rst = 1'b0;

    sv = 1'b1; sin = 8'd200;
    cycle();
    sv = 1'b0;
    wait_req(0, 300, n);
    chk("first_req_lat", n, 255);
    chk("first_und", int'(und1), 0);

    rp(0, -1, 0, -1, 0, h, u);   chk("duty200", h, 200); chk("underrun", u, 1);
    rp(255, 10, 0, -1, 1, h, u); chk("duty_held", h, 200); chk("no_und", u, 0);
    rp(0, 10, 0, -1, 1, h, u);   chk("att1_255", h, 191);
    rp(255, 10, 0, -1, 3, h, u); chk("att1_0", h, 64);
    rp(0, 10, 0, -1, 3, h, u);   chk("att3_255", h, 143);
    rp(50, 256, 0, -1, 0, h, u); chk("att3_0", h, 112); chk("bypass_und", u, 0);
    rp(10, 10, 20, 20, 0, h, u); chk("bypass50", h, 50);

    h = 0;
    for (int i = 1; i <= 100; i++) begin
      sv = (i == 50); sin = 8'd77;
      cycle();
      h += int'(pwm1);
    end
    sv = 1'b0;
    chk("overwrite20", h, 20);
    rst = 1'b1;
    cycle();
    chk("midrst_pwm", int'(pwm1), 0);
    chk("midrst_req", int'(req1), 0);
    rst = 1'b0;
    wait_req(0, 300, n);
    chk("postrst_lat", n, 256);
    chk("staged_discarded", int'(und1), 1);
    rp(0, -1, 0, -1, 0, h, u);   chk("postrst_duty0", h, 0);

    wait_req(1, 1100, n);
    wait_req(1, 1100, n);
    chk("p4_period", n, 1024);
    n = 0;
    do begin
      en = !(n >= 300 && n < 310);
      cycle();
      n++;
      if (n >= 301 && n <= 310) chk("en_low_pwm", int'(pwm4), 0);
    end while (req4 == 1'b0 && n < 1200);
    en = 1'b1;
    chk("req_seen", int'(req4), 1);
    chk("p4_period_en", n, 1034);

    for (int i = 0; i < 3000; i++) begin
      sv  = ($urandom % 4) == 0;
      sin = 8'($urandom);
      att = 2'($urandom);
      en  = ($urandom % 16) != 0;
      rst = ($urandom % 700) == 0;
      cycle();
    end
    rst = 1'b0; en = 1'b1; sv = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
